// File: rtl/bop_buffer_ctrl_pkg.sv
// Shared BOP definitions: insert payload, controller states and default sizing.
package bop_buffer_ctrl_pkg;

  localparam int BOP_NUM_ENTRIES = 8;
  localparam int BOP_STARVE_MAX  = 4;

  typedef struct packed {
    logic [31:0] first;
    logic [31:0] last;
  } bop_ins_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } bop_ctrl_state_e;

endpackage

// File: rtl/bop_buffer_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; r_rr holds the last granted ID so the other side wins a tie.
module bop_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic r_rr;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) gnt_o = r_rr ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)       r_rr <= 1'b1;
    else if (|gnt_o) r_rr <= gnt_o[1];
  end

endmodule

// File: rtl/bop_buffer_ctrl.sv
// Arbitrates the circular buffer's lookup port between load/store checks, serialises
// interval inserts through a one-entry holding register, and sequences entry flushes.
module bop_buffer_ctrl
  import bop_buffer_ctrl_pkg::*;
#(
  parameter int NUM_ENTRIES = BOP_NUM_ENTRIES,
  parameter int IDX_W       = $clog2(NUM_ENTRIES),
  parameter int STARVE_MAX  = BOP_STARVE_MAX
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             flush_i,
  output logic             flush_busy_o,
  input  logic [1:0]       lk_valid_i,
  input  logic [1:0][31:0] lk_addr_i,
  output logic [1:0]       lk_ready_o,
  output logic             rsp_valid_o,
  output logic             rsp_id_o,
  output logic             rsp_in_range_o,
  output logic             rsp_is_first_o,
  input  logic             ins_valid_i,
  input  logic [31:0]      ins_first_i,
  input  logic [31:0]      ins_last_i,
  output logic             ins_ready_o,
  output logic             buf_wr_en_o,
  output logic [31:0]      buf_first_o,
  output logic [31:0]      buf_last_o,
  output logic [31:0]      buf_addr_o,
  input  logic             buf_in_range_i,
  input  logic             buf_is_first_i,
  output logic             buf_clr_en_o,
  output logic [IDX_W-1:0] buf_clr_idx_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  bop_ctrl_state_e r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_pend;
  bop_ins_t         r_ins;
  logic [SW-1:0]    r_starve;
  logic             r_rsp_valid, r_rsp_id, r_rsp_in_range, r_rsp_is_first;

  logic       w_run, w_force, w_drain, w_ins_rdy, w_lk_ok;
  logic [1:0] w_req, w_gnt;

  // A flush request in RUN already blocks drains, inserts and grants this cycle.
  assign w_run     = (r_state == RUN) && !rst_i;
  assign w_force   = (r_starve == SW'(STARVE_MAX)) && (|lk_valid_i);
  assign w_drain   = r_pend && w_run && !w_force && !flush_i;
  assign w_ins_rdy = w_run && !flush_i && (!r_pend || w_drain);
  assign w_lk_ok   = w_run && !flush_i && !w_drain;
  assign w_req     = lk_valid_i & {2{w_lk_ok}};

  bop_rr_arb2 u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (w_req),
    .gnt_o (w_gnt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= RUN;
      r_idx          <= '0;
      r_pend         <= 1'b0;
      r_ins          <= '0;
      r_starve       <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_id       <= 1'b0;
      r_rsp_in_range <= 1'b0;
      r_rsp_is_first <= 1'b0;
    end else begin
      case (r_state)
        RUN: if (flush_i) begin
          r_state <= FLUSH;
          r_idx   <= '0;
        end
        FLUSH: begin
          if (flush_i) r_idx <= '0;
          else if (r_idx == IDX_W'(NUM_ENTRIES - 1)) begin
            r_state <= RUN;
            r_idx   <= '0;
          end else r_idx <= r_idx + 1'b1;
        end
        default: r_state <= RUN;
      endcase

      // Disabled unit still acks inserts but never arms the holding register.
      if (flush_i || r_state == FLUSH) r_pend <= 1'b0;
      else if (w_ins_rdy && ins_valid_i) begin
        r_pend <= en_i;
        r_ins  <= '{first: ins_first_i, last: ins_last_i};
      end else if (w_drain) r_pend <= 1'b0;

      if (|w_gnt) r_starve <= '0;
      else if ((|lk_valid_i) && w_drain && r_starve != SW'(STARVE_MAX))
        r_starve <= r_starve + 1'b1;

      r_rsp_valid    <= |w_gnt;
      r_rsp_id       <= w_gnt[1];
      r_rsp_in_range <= (|w_gnt) & buf_in_range_i & en_i;
      r_rsp_is_first <= (|w_gnt) & buf_is_first_i & en_i;
    end
  end

  assign flush_busy_o   = (r_state == FLUSH);
  assign lk_ready_o     = w_gnt;
  assign ins_ready_o    = w_ins_rdy;
  assign buf_wr_en_o    = w_drain;
  assign buf_first_o    = w_drain ? r_ins.first : '0;
  assign buf_last_o     = w_drain ? r_ins.last  : '0;
  assign buf_addr_o     = w_gnt[1] ? lk_addr_i[1] : (w_gnt[0] ? lk_addr_i[0] : '0);
  assign buf_clr_en_o   = (r_state == FLUSH);
  assign buf_clr_idx_o  = (r_state == FLUSH) ? r_idx : '0;
  assign rsp_valid_o    = r_rsp_valid;
  assign rsp_id_o       = r_rsp_id;
  assign rsp_in_range_o = r_rsp_in_range;
  assign rsp_is_first_o = r_rsp_is_first;

endmodule

// File: tb/tb_bop_buffer_ctrl.sv
// Directed bench: stimulus pushes expected responses/writes into queues, negedge monitors pop and compare.
module tb_bop_buffer_ctrl;

  localparam int N  = 8;
  localparam int IW = 3;

  logic             clk = 1'b0;
  logic             rst, en, flush;
  logic             flush_busy;
  logic [1:0]       lk_valid;
  logic [1:0][31:0] lk_addr;
  logic [1:0]       lk_ready;
  logic             rsp_valid, rsp_id, rsp_ir, rsp_if;
  logic             ins_valid;
  logic [31:0]      ins_first, ins_last;
  logic             ins_ready;
  logic             wr_en;
  logic [31:0]      wr_first, wr_last, baddr;
  logic             bir, bif;
  logic             clr_en;
  logic [IW-1:0]    clr_idx;

  int errors = 0;
  int checks = 0;
  logic [2:0]  rq[$];
  logic [63:0] wq[$];

  always #5 clk = ~clk;

  bop_buffer_ctrl #(.NUM_ENTRIES(N), .IDX_W(IW), .STARVE_MAX(4)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .flush_i(flush), .flush_busy_o(flush_busy),
    .lk_valid_i(lk_valid), .lk_addr_i(lk_addr), .lk_ready_o(lk_ready),
    .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_in_range_o(rsp_ir), .rsp_is_first_o(rsp_if),
    .ins_valid_i(ins_valid), .ins_first_i(ins_first), .ins_last_i(ins_last), .ins_ready_o(ins_ready),
    .buf_wr_en_o(wr_en), .buf_first_o(wr_first), .buf_last_o(wr_last), .buf_addr_o(baddr),
    .buf_in_range_i(bir), .buf_is_first_i(bif), .buf_clr_en_o(clr_en), .buf_clr_idx_o(clr_idx)
  );

  task automatic ck(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (rq.size() == 0) ck("rsp_unexpected", {rsp_id, rsp_ir, rsp_if}, 64'hdead);
      else ck("rsp", {rsp_id, rsp_ir, rsp_if}, rq.pop_front());
    end
    if (wr_en) begin
      if (wq.size() == 0) ck("wr_unexpected", {wr_first, wr_last}, 64'hdead);
      else ck("wr", {wr_first, wr_last}, wq.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Settle, compare the cycle's combinational handshakes, and queue the response a grant implies.
  task automatic chk(input logic [1:0] e_lk, input logic e_wr, input logic e_ir, input string nm);
    #1;
    ck({nm, ".lk"}, lk_ready, e_lk);
    ck({nm, ".wr"}, wr_en, e_wr);
    ck({nm, ".ir"}, ins_ready, e_ir);
    if (e_lk != 2'b00) rq.push_back({e_lk[1], bir & en, bif & en});
  endtask

  task automatic fchk(input int idx, input string nm);
    #1;
    ck(nm, {flush_busy, clr_en, 5'(clr_idx), lk_ready, wr_en, ins_ready},
           {1'b1, 1'b1, 5'(idx), 2'b00, 1'b0, 1'b0});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    ck("reset_outs", {flush_busy, lk_ready, rsp_valid, ins_ready, wr_en, clr_en, baddr},
                     {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; flush = 1'b0; lk_valid = '0; lk_addr = '0;
    ins_valid = 1'b0; ins_first = '0; ins_last = '0; bir = 1'b0; bif = 1'b0;
    do_reset();

    // single requester on port 0
    tick(); lk_valid = 2'b01; lk_addr[0] = 32'h1000; bir = 1'b1; bif = 1'b0;
    chk(2'b01, 1'b0, 1'b1, "t1");
    ck("t1.addr", baddr, 32'h1000);
    tick(); lk_valid = 2'b00; bir = 1'b0;
    chk(2'b00, 1'b0, 1'b1, "t1.idle");

    // round robin from reset: 0,1,0,1
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick(); lk_valid = 2'b11; lk_addr[0] = 32'hA000 + k; lk_addr[1] = 32'hB000 + k;
      bir = k[0]; bif = ~k[0];
      chk((k % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 1'b1, $sformatf("t2.%0d", k));
      ck($sformatf("t2.addr%0d", k), baddr, (k % 2 == 0) ? 32'hA000 + k : 32'hB000 + k);
    end
    tick(); lk_valid = 2'b00; bir = 1'b0; bif = 1'b0;
    chk(2'b00, 1'b0, 1'b1, "t2.idle");

    // insert drains ahead of port 1, which is granted next cycle
    tick(); ins_valid = 1'b1; ins_first = 32'h2000; ins_last = 32'h2010;
    chk(2'b00, 1'b0, 1'b1, "t3.acc");
    wq.push_back({32'h2000, 32'h2010});
    tick(); ins_valid = 1'b0; lk_valid = 2'b10; lk_addr[1] = 32'h3000;
    chk(2'b00, 1'b1, 1'b1, "t3.drain");
    tick(); chk(2'b10, 1'b0, 1'b1, "t3.grant");
    tick(); lk_valid = 2'b00;
    chk(2'b00, 1'b0, 1'b1, "t3.idle");

    // continuous inserts starve port 0 for 4 cycles, then it is forced through
    tick(); ins_valid = 1'b1; ins_first = 32'h4000; ins_last = 32'h4004;
    chk(2'b00, 1'b0, 1'b1, "t4.acc0");
    wq.push_back({32'h4000, 32'h4004});
    for (int k = 1; k <= 4; k++) begin
      tick(); ins_first = 32'h4000 + 32'h10 * k; ins_last = 32'h4004 + 32'h10 * k;
      lk_valid = 2'b01; lk_addr[0] = 32'h5000; bir = 1'b1;
      chk(2'b00, 1'b1, 1'b1, $sformatf("t4.blk%0d", k));
      wq.push_back({32'h4000 + 32'h10 * k, 32'h4004 + 32'h10 * k});
    end
    tick(); ins_first = 32'h4050; ins_last = 32'h4054;
    chk(2'b01, 1'b0, 1'b0, "t4.force");
    tick(); lk_valid = 2'b00; bir = 1'b0;
    chk(2'b00, 1'b1, 1'b1, "t4.resume");
    wq.push_back({32'h4050, 32'h4054});
    tick(); ins_valid = 1'b0;
    chk(2'b00, 1'b1, 1'b1, "t4.last");
    tick(); chk(2'b00, 1'b0, 1'b1, "t4.idle");

    // flush drops the pending insert and blocks everything for N cycles
    tick(); ins_valid = 1'b1; ins_first = 32'h6000; ins_last = 32'h6008;
    chk(2'b00, 1'b0, 1'b1, "t5.acc");
    tick(); ins_valid = 1'b0; flush = 1'b1; lk_valid = 2'b01; lk_addr[0] = 32'h8000;
    chk(2'b00, 1'b0, 1'b0, "t5.req");
    for (int i = 0; i < N; i++) begin
      tick(); flush = 1'b0;
      fchk(i, $sformatf("t5.f%0d", i));
    end
    tick(); chk(2'b01, 1'b0, 1'b1, "t5.after");
    ck("t5.busy_off", flush_busy, 1'b0);
    tick(); lk_valid = 2'b01; lk_addr[0] = 32'h8100;
    chk(2'b01, 1'b0, 1'b1, "t5.pre");
    tick(); lk_valid = 2'b00; flush = 1'b1;
    chk(2'b00, 1'b0, 1'b0, "t5.req2");
    for (int i = 0; i <= 5; i++) begin
      tick(); flush = (i == 5);
      fchk(i, $sformatf("t5.g%0d", i));
    end
    for (int i = 0; i < N; i++) begin
      tick(); flush = 1'b0;
      fchk(i, $sformatf("t5.r%0d", i));
    end
    tick(); chk(2'b00, 1'b0, 1'b1, "t5.done");
    ck("t5.busy_end", {flush_busy, clr_en}, 2'b00);

    // disabled unit: lookup result masked, inserts acked but never written
    tick(); en = 1'b0; lk_valid = 2'b01; lk_addr[0] = 32'h9000; bir = 1'b1; bif = 1'b1;
    chk(2'b01, 1'b0, 1'b1, "t6.lk");
    tick(); lk_valid = 2'b00; ins_valid = 1'b1; ins_first = 32'h7000; ins_last = 32'h7010;
    chk(2'b00, 1'b0, 1'b1, "t6.ins");
    tick(); ins_valid = 1'b0;
    chk(2'b00, 1'b0, 1'b1, "t6.nowr");
    tick(); chk(2'b00, 1'b0, 1'b1, "t6.idle");
    en = 1'b1; bir = 1'b0; bif = 1'b0;

    tick(); tick(); tick();
    ck("rsp_q_empty", rq.size(), 0);
    ck("wr_q_empty", wq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
